// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with direct-hold and dwell-paced scan modes.
// Define SEQ_DECODER_ACTIVE_LOW_EN to drive out inverted (idle = all ones).
module seq_decoder #(
  parameter  int ADDR_W  = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               load,
  input  logic               mode,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic [ADDR_W-1:0]  cur,
  output logic               busy,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   line_q, line_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [ADDR_W-1:0]  idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wrap_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      line_d  = '0;
    end else if (load) begin
      // a load always wins over a pending scan advance
      state_d = mode ? SCAN : HOLD;
      idx_d   = address;
      cnt_d   = '0;
      line_d  = OUT_W'(1) << address;
      if (mode) dwell_d = dwell;
    end else begin
      unique case (state_q)
        IDLE: line_d = '0;
        HOLD: line_d = line_q;
        SCAN: begin
          if (cnt_q == dwell_q) begin
            idx_d  = idx_inc;
            cnt_d  = '0;
            line_d = OUT_W'(1) << idx_inc;
            wrap_d = &idx_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          line_d  = '0;
        end
      endcase
    end
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef SEQ_DECODER_ACTIVE_LOW_EN
  assign out = ~line_q;
`else
  assign out = line_q;
`endif
  assign cur  = idx_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder: directed steps push expectations,
// a negedge monitor pops and compares them.
module tb_seq_decoder;

  logic       clk = 1'b0;
  logic       rst_n, enable, load, mode;
  logic [2:0] address;
  logic [7:0] dwell;
  logic [7:0] out;
  logic [2:0] cur;
  logic       busy, wrap;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] o;
    logic [2:0] c;
    logic       b;
    logic       w;
    string      nm;
  } exp_t;

  exp_t sb[$];

  seq_decoder #(.ADDR_W(3), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .mode(mode), .address(address), .dwell(dwell),
    .out(out), .cur(cur), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int l);
    logic [7:0] v;
    v = 8'h00;
    if (l >= 0) v[l] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic r, input logic en, input logic ld,
                      input logic md, input logic [2:0] a,
                      input logic [7:0] dw, input int line,
                      input logic [2:0] ec, input logic eb,
                      input logic ew, input string nm);
    exp_t e;
    rst_n = r; enable = en; load = ld; mode = md;
    address = a; dwell = dw;
    e.o = oh(line); e.c = ec; e.b = eb; e.w = ew; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] eo, act_hi;
      e = sb.pop_front();
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
      eo = ~e.o;
      act_hi = ~out;
`else
      eo = e.o;
      act_hi = out;
`endif
      total++;
      if ({out, cur, busy, wrap} === {eo, e.c, e.b, e.w}) passed++;
      else $display("FAIL %s: out=%b cur=%0d busy=%b wrap=%b, required out=%b cur=%0d busy=%b wrap=%b",
                    e.nm, out, cur, busy, wrap, eo, e.c, e.b, e.w);
      total++;
      if ($countones(act_hi) <= 1) passed++;
      else $display("FAIL onehot_%s: out=%b, required at most one active line", e.nm, out);
    end
  end

  initial begin
    int c3[10];
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; mode = 1'b0;
    address = '0; dwell = '0;
    #1;
    // reset wins over a concurrent load
    step(0, 1, 1, 0, 3'd5, 8'd0, -1, 3'd0, 0, 0, "reset0");
    step(0, 1, 1, 1, 3'd5, 8'd0, -1, 3'd0, 0, 0, "reset1");
    // direct
    step(1, 1, 1, 0, 3'd5, 8'd0, 5, 3'd5, 0, 0, "direct5");
    step(1, 1, 0, 0, 3'd0, 8'd0, 5, 3'd5, 0, 0, "hold5");
    // scan from 6, dwell 2
    c3 = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++)
      step(1, 1, i == 0, 1, 3'd6, 8'd2, c3[i], 3'(c3[i]), 1, i == 6,
           $sformatf("scan_d2_%0d", i));
    // dwell 0 from address 0
    for (int i = 0; i < 17; i++)
      step(1, 1, i == 0, 1, 3'd0, 8'd0, i % 8, 3'(i % 8), 1,
           (i != 0) && (i % 8 == 0), $sformatf("scan_d0_%0d", i));
    // enable drop mid-scan at line 3, load ignored
    step(1, 1, 1, 1, 3'd3, 8'd5, 3, 3'd3, 1, 0, "scan3");
    step(1, 0, 1, 0, 3'd6, 8'd0, -1, 3'd0, 0, 0, "en_drop");
    step(1, 1, 0, 0, 3'd6, 8'd0, -1, 3'd0, 0, 0, "idle_after");
    // load collides with a wrapping advance
    step(1, 1, 1, 1, 3'd7, 8'd1, 7, 3'd7, 1, 0, "scan7");
    step(1, 1, 0, 1, 3'd7, 8'd1, 7, 3'd7, 1, 0, "scan7b");
    step(1, 1, 1, 0, 3'd1, 8'd0, 1, 3'd1, 0, 0, "collide");
    step(1, 1, 0, 0, 3'd0, 8'd0, 1, 3'd1, 0, 0, "hold1");
    // reset mid-scan does not resume
    step(1, 1, 1, 1, 3'd2, 8'd0, 2, 3'd2, 1, 0, "scan2");
    step(1, 1, 0, 0, 3'd0, 8'd0, 3, 3'd3, 1, 0, "scan3b");
    step(0, 1, 0, 0, 3'd0, 8'd0, -1, 3'd0, 0, 0, "mid_reset");
    step(1, 1, 0, 0, 3'd0, 8'd0, -1, 3'd0, 0, 0, "post_reset");
    step(1, 1, 1, 0, 3'd2, 8'd0, 2, 3'd2, 0, 0, "direct2");
    // drain scoreboard with a bounded wait
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d pending, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
